// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: IDLE/BUSY/DONE FSM servicing loads and
// stores against an internal word array. Optional misalignment fault via `DMEM_ALIGN_CHECK_EN`.
module dmem_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("dmem_responder: DEPTH must be a power of 2, at least 2");
        end
        if (LATENCY < 1) begin : g_bad_latency
            $error("dmem_responder: LATENCY must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic               wr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic               fault_q;
    logic               req;
    logic               access;
    logic [31:0]        mem [DEPTH];

    // Only the word-index bits of the address select storage; the rest wrap away.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

    assign req    = MemRead_i | MemWrite_i;
    assign access = (state == BUSY) && (cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = BUSY;
            BUSY:    if (cnt == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall_o = 1'b0;
        done_o  = 1'b0;
        err_o   = 1'b0;
        case (state)
            IDLE: stall_o = req;
            BUSY: stall_o = 1'b1;
            DONE: begin
                done_o = 1'b1;
                err_o  = fault_q;
            end
            default: ;
        endcase
    end

    // Request capture, latency countdown and read-data register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt     <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            data_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        wr_q    <= MemWrite_i;
                        idx_q   <= addr_i[IDX_W+1:2];
                        wdata_q <= data_i;
                        cnt     <= CNT_W'(LATENCY - 1);
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!wr_q && !fault_q) begin
                        data_o <= mem[idx_q];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fault_q <= 1'b0;
        end else if (state == IDLE && req) begin
            fault_q <= (addr_i[1:0] != 2'b00);
        end
    end
`else
    assign fault_q = 1'b0;
`endif

    // NOTE: the array has no reset; reset forces IDLE, so an in-flight store never reaches this write.
    always_ff @(posedge clk_i) begin
        if (access && wr_q && !fault_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

    localparam int DEPTH   = 32;
    localparam int LATENCY = 3;
    localparam int BUDGET  = 20;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        stall_o;
    logic        done_o;
    logic        err_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_data;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .MemRead_i  (MemRead_i),
        .MemWrite_i (MemWrite_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_misaligned(input logic [31:0] addr);
`ifdef DMEM_ALIGN_CHECK_EN
        return (addr % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr % (4 * DEPTH)) / 4);
    endfunction

    task automatic quiet_cycle(input string tag);
        @(negedge clk_i);
        #1;
        check({tag, " stall"}, 32'(stall_o), 32'd0);
        check({tag, " done"},  32'(done_o),  32'd0);
        check({tag, " err"},   32'(err_o),   32'd0);
        check({tag, " data"},  data_o,       exp_data);
    endtask

    // Issue one request, hold it until completion, check timing and results against the model.
    task automatic req(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input string tag);
        int  cyc;
        int  stalls;
        bit  got;
        bit  is_wr;
        bit  fault;
        @(negedge clk_i);
        MemRead_i  = rd;
        MemWrite_i = wr;
        addr_i     = addr;
        data_i     = data;
        #1;
        cyc = 0; stalls = 0; got = 1'b0;
        while (!got && cyc < BUDGET) begin
            if (done_o) begin
                got = 1'b1;
            end else begin
                if (stall_o) stalls++;
                @(negedge clk_i);
                #1;
                cyc++;
            end
        end
        check({tag, " completed"}, 32'(got), 32'd1);
        is_wr = wr;
        fault = is_misaligned(addr);
        if (!fault) begin
            if (is_wr) model_mem[word_of(addr)] = data;
            else       exp_data = model_mem[word_of(addr)];
        end
        check({tag, " stall cycles"}, 32'(stalls),  32'(LATENCY + 1));
        check({tag, " done cycle"},   32'(cyc),     32'(LATENCY + 1));
        check({tag, " stall in done"}, 32'(stall_o), 32'd0);
        check({tag, " err"},          32'(err_o),   32'(fault));
        check({tag, " data"},         data_o,       exp_data);
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
    endtask

    initial begin
        logic [31:0] old_0c;
        rst_i      = 1'b0;
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        addr_i     = '0;
        data_i     = '0;
        exp_data   = '0;

        // Reset held with no requests, then released: outputs stay quiet.
        repeat (3) quiet_cycle("reset");
        rst_i = 1'b1;
        repeat (3) quiet_cycle("post reset");

        // Give every word a known random value.
        for (int i = 0; i < DEPTH; i++) begin
            req(1'b0, 1'b1, 32'(i * 4), $urandom, "fill");
        end

        req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "store 0x10");
        quiet_cycle("after store");
        req(1'b1, 1'b0, 32'h10, 32'h0, "load 0x10");
        check("load 0x10 value", data_o, 32'hDEADBEEF);

        req(1'b0, 1'b1, 32'h04, 32'h1234, "store 0x04");
        req(1'b1, 1'b0, 32'h84, 32'h0, "wrap load 0x84");
        check("wrap value", data_o, 32'h1234);

        req(1'b1, 1'b1, 32'h08, 32'h55, "both 0x08");
        req(1'b1, 1'b0, 32'h08, 32'h0, "load 0x08");
        check("both-as-write value", data_o, 32'h55);

        // Reset while a store is in flight: store discarded, data_o cleared.
        old_0c = model_mem[3];
        @(negedge clk_i);
        MemWrite_i = 1'b1;
        addr_i     = 32'h0C;
        data_i     = 32'hAAAA;
        repeat (2) @(negedge clk_i);
        #1;
        check("busy before reset", 32'(stall_o), 32'd1);
        rst_i      = 1'b0;
        MemWrite_i = 1'b0;
        exp_data   = '0;
        #1;
        check("mid reset data", data_o, 32'd0);
        quiet_cycle("mid reset");
        rst_i = 1'b1;
        quiet_cycle("after mid reset");
        req(1'b1, 1'b0, 32'h0C, 32'h0, "load 0x0C after reset");
        check("0x0C kept old", data_o, old_0c);

        // Misaligned store: faulted when the alignment check is built in, word write otherwise.
        req(1'b0, 1'b1, 32'h0D, 32'h77, "store 0x0D");
        quiet_cycle("after 0x0D");
        req(1'b1, 1'b0, 32'h0C, 32'h0, "load 0x0C");

        // Random traffic with random idle gaps, including back-to-back requests.
        for (int n = 0; n < 60; n++) begin
            int op;
            int gap;
            op  = $urandom_range(0, 2);
            gap = $urandom_range(0, 2);
            req(op != 1, op != 0, $urandom, $urandom, "random");
            for (int g = 0; g < gap; g++) quiet_cycle("random gap");
        end

        // Read back the whole array.
        for (int i = 0; i < DEPTH; i++) begin
            req(1'b1, 1'b0, 32'(i * 4), 32'h0, "readback");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
